// File: rtl/ahb_slave_mem_if.sv
// AHB bus bundle between one master and the memory slave; signal names follow the AMBA AHB names.
interface ahb_slave_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HBURST;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;
  logic [1:0]        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA,
    output HREADY, HRDATA, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA,
    input  HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB slave word memory: programmable OKAY wait states, byte/half/word lanes, two-cycle ERROR.
// Read data is loaded at the address-accept edge; writes commit at the edge ending the data phase.
module ahb_slave_mem #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           HRESET,
  ahb_slave_mem_if.slave bus
);
  localparam int               BYTES  = DATA_W / 8;
  localparam int               LANE_W = $clog2(BYTES);
  localparam int               IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  SPAN   = (ADDR_W + 1)'(DEPTH * BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic              r_hready;
  logic [1:0]        r_hresp;
  logic [DATA_W-1:0] r_hrdata;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [2:0]        r_size;
  logic [LANE_W-1:0] r_lane;
  logic [IDX_W-1:0]  r_idx;

  logic              w_accept;
  logic [ADDR_W:0]   w_diff;
  logic              w_in_range;
  logic              w_size_bad;
  logic [2:0]        w_mask;
  logic              w_misalign;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [BYTES-1:0]  w_be;
  logic [DATA_W-1:0] w_merged;
  logic              w_commit;
  logic              w_unused;

  assign w_accept   = bus.HSEL & bus.HTRANS[1] & r_hready;
  // One extra bit so an address below BASE_ADDR wraps to a huge offset and fails the range check.
  assign w_diff     = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
  assign w_in_range = (w_diff < SPAN);
  assign w_size_bad = (bus.HSIZE > 3'(LANE_W));
  assign w_mask     = 3'((4'd1 << bus.HSIZE[1:0]) - 4'd1);
  assign w_misalign = |(bus.HADDR[2:0] & w_mask);
  assign w_err      = ~w_in_range | w_size_bad | w_misalign;
  assign w_idx      = w_diff[LANE_W +: IDX_W];
  assign w_commit   = (r_state == S_DATA) & r_write & ~HRESET;
  assign w_unused   = ^{bus.HBURST, bus.HTRANS[0], w_diff};

  always_comb begin
    w_be     = '0;
    w_merged = r_mem[r_idx];
    for (int b = 0; b < BYTES; b++) begin
      if ((b >= int'(r_lane)) && (b < int'(r_lane) + (1 << r_size))) begin
        w_be[b] = 1'b1;
      end
      if (w_be[b]) begin
        w_merged[b*8 +: 8] = bus.HWDATA[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= 2'b00;
      r_hrdata <= '0;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_lane   <= '0;
      r_idx    <= '0;
    end else begin
      if (w_accept) begin
        r_write <= bus.HWRITE;
        r_size  <= bus.HSIZE;
        r_lane  <= bus.HADDR[LANE_W-1:0];
        r_idx   <= w_idx;
      end
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state  <= S_DATA;
            r_hready <= 1'b1;
            r_hresp  <= 2'b00;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 2'b01;
        end
        default: begin
          if (w_accept && w_err) begin
            r_state  <= S_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= 2'b01;
          end else if (w_accept) begin
            // A write to the same word committing on this edge must be visible to the read.
            if (!bus.HWRITE) begin
              r_hrdata <= (w_commit && (r_idx == w_idx)) ? w_merged : r_mem[w_idx];
            end
            r_hresp <= 2'b00;
            if (WAIT_STATES == 0) begin
              r_state  <= S_DATA;
              r_hready <= 1'b1;
            end else begin
              r_state  <= S_WAIT;
              r_hready <= 1'b0;
              r_cnt    <= 4'(WAIT_STATES);
            end
          end else begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 2'b00;
          end
        end
      endcase
    end
  end

  assign bus.HREADY = r_hready;
  assign bus.HRESP  = r_hresp;
  assign bus.HRDATA = r_hrdata;
endmodule
